dma_port_ctrl: RTL

- Parametrised local-bus DMA channel controller. Successor to the fixed 16-channel decoder: it is fully synchronous to LCLK, has a configurable channel count and decode field, and adds a burst state machine, per-beat strobes, beat counting and error flags.
- Sits between the PCI-bridge local bus (ADDR/ADSn/LWR/BLASTn) and the per-channel acquisition FIFOs. It drives write strobes into the FIFOs and read/pop strobes out of them.

---
 rtl/dma_port_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dma_port_ctrl.sv
// Local-bus DMA channel controller: window/channel decode, IDLE/DATA/TURN burst FSM,
// per-beat FIFO strobes, beat counting, miss and sticky error flags. Optional macro: DMA_BURST_LIMIT_EN.
module dma_port_ctrl #(
    parameter int NUM_CH    = 16,
    parameter int CH_W      = 4,
    parameter int CH_LSB    = 13,
    parameter int BASE_BIT  = 21,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 9
) (
    input  logic              LCLK,
    input  logic              LRESETn,
    input  logic [31:2]       ADDR,
    input  logic              ADSn,
    input  logic              LWR,
    input  logic              BLASTn,
    output logic [NUM_CH-1:0] dmaw,
    output logic [NUM_CH-1:0] dmar,
    output logic              DMAChannelInk,
    output logic [CH_W-1:0]   cur_ch,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              miss,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_TURN = 2'd2;

`ifdef DMA_BURST_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic [1:0]        state_reg;
    logic              wr_reg;
    logic              last_reg;
    logic [31:2]       other_mask;
    logic [CH_W-1:0]   ch_field;
    logic [NUM_CH-1:0] field_onehot;
    logic [NUM_CH-1:0] cur_onehot;
    logic              hit;
    logic              last_beat;
    logic              limit_hit;
    logic [CNT_W-1:0]  cnt_inc;

    // Address bits that must be zero for a hit: everything except the window bit and channel field.
    genvar gi;
    generate
        for (gi = 2; gi < 32; gi++) begin : g_mask
            assign other_mask[gi] = (gi != BASE_BIT) && ((gi < CH_LSB) || (gi >= CH_LSB + CH_W));
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
            assign field_onehot[gi] = (ch_field == CH_W'(gi));
            assign cur_onehot[gi]   = (cur_ch == CH_W'(gi));
        end
    endgenerate

    assign ch_field = ADDR[CH_LSB+CH_W-1:CH_LSB];
    assign hit      = ADDR[BASE_BIT] && ((ADDR & other_mask) == '0) && (int'(ch_field) < NUM_CH);
    assign cnt_inc  = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

    // A single-beat burst flags BLASTn together with ADSn, so that marker is carried into DATA.
    assign last_beat = !BLASTn || last_reg;
    assign limit_hit = LIMIT_EN && !last_beat && (cnt_inc == CNT_W'(MAX_BEATS));

    always_ff @(posedge LCLK or negedge LRESETn) begin
        if (!LRESETn) begin
            state_reg     <= ST_IDLE;
            wr_reg        <= 1'b0;
            last_reg      <= 1'b0;
            dmaw          <= '0;
            dmar          <= '1;
            DMAChannelInk <= 1'b1;
            cur_ch        <= '0;
            beat_cnt      <= '0;
            miss          <= 1'b0;
            err           <= 1'b0;
        end else begin
            miss <= 1'b0;
            dmaw <= '0;
            dmar <= '1;
            case (state_reg)
                ST_IDLE: begin
                    if (!ADSn && hit) begin
                        cur_ch        <= ch_field;
                        wr_reg        <= LWR;
                        last_reg      <= !BLASTn;
                        beat_cnt      <= '0;
                        DMAChannelInk <= 1'b0;
                        state_reg     <= ST_DATA;
                        // Read pop leads the beat so the FIFO output is valid during it.
                        if (!LWR) begin
                            dmar <= ~field_onehot;
                        end
                    end else if (!ADSn && ADDR[BASE_BIT]) begin
                        miss <= 1'b1;
                    end
                end
                ST_DATA: begin
                    beat_cnt <= cnt_inc;
                    if (wr_reg) begin
                        dmaw <= cur_onehot;
                    end
                    if (!ADSn || limit_hit) begin
                        err <= 1'b1;
                    end
                    if (last_beat || limit_hit) begin
                        state_reg <= ST_TURN;
                    end else if (!wr_reg) begin
                        dmar <= ~cur_onehot;
                    end
                end
                ST_TURN: begin
                    DMAChannelInk <= 1'b1;
                    last_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    DMAChannelInk <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
